// File: rtl/spi_master_mc_if.sv
// Bus bundle between the system-side command logic and the SPI pins of
// spi_master_mc. The master modport is the controller's view.
interface spi_master_mc_if #(
    parameter int DATA_W = 12,
    parameter int NUM_CS = 1,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) ();
    logic              newd;
    logic [DATA_W-1:0] din;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic              miso;
    logic              sclk;
    logic [NUM_CS-1:0] cs_n;
    logic              mosi;
    logic [DATA_W-1:0] dout;
    logic              done;
    logic              busy;

    modport master (
        input  newd, din, cs_sel, cpol, cpha, lsb_first, miso,
        output sclk, cs_n, mosi, dout, done, busy
    );

    modport slave (
        output newd, din, cs_sel, cpol, cpha, lsb_first, miso,
        input  sclk, cs_n, mosi, dout, done, busy
    );
endinterface

// File: rtl/spi_master_mc.sv
// Parametrised full-duplex SPI master: configurable word width and SCLK
// divider, per-transfer CPOL/CPHA/bit order, one-hot active-low chip selects.
// Sequence per transfer: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
module spi_master_mc #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 1,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input logic             clk,
    input logic             rst,
    spi_master_mc_if.master bus
);
    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edg_q, edg_d, edg_nxt;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d, cs_n_sel;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              sclk_q, sclk_d, mosi_q, mosi_d;
    logic              done_q, done_d, busy_q, busy_d;
    logic              cnt_wrap, fire, sel_ok;

    // Bit currently at the head of the transmit register for the chosen order.
    function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    // Transmit register after the head bit has been consumed.
    function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    // Receive register with a new bit inserted so the word ends up in transmit order.
    function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] v, input logic b,
                                                   input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign edg_nxt  = edg_q + 1'b1;
    assign sel_ok   = (32'(bus.cs_sel) < NUM_CS);

    // Decode the requested slave index into a one-hot-low chip-select pattern.
    always_comb begin
        for (int i = 0; i < NUM_CS; i++) begin
            cs_n_sel[i] = (32'(bus.cs_sel) != i);
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        // NOTE: every target gets a default here, so no path can leave one
        // unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        edg_d   = edg_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cs_n_d  = cs_n_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        fire    = 1'b0;

        unique case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                cnt_d  = '0;
                edg_d  = '0;
                cs_n_d = '1;
                busy_d = 1'b0;
                if (bus.newd && sel_ok) begin
                    state_d = SETUP;
                    busy_d  = 1'b1;
                    cs_n_d  = cs_n_sel;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    lsb_d   = bus.lsb_first;
                    rx_d    = '0;
                    tx_d    = bus.din;
                    // With CPHA=0 the first bit must be on MOSI before the first edge.
                    if (!bus.cpha) begin
                        mosi_d = head_bit(bus.din, bus.lsb_first);
                        tx_d   = drop_head(bus.din, bus.lsb_first);
                    end
                end
            end
            SETUP: begin
                sclk_d = cpol_q;
                cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
                if (cnt_wrap) begin
                    fire    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
                if (cnt_wrap) begin
                    fire = 1'b1;
                    if (edg_nxt == EDGE_LAST) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
                if (cnt_wrap) begin
                    state_d = IDLE;
                    cs_n_d  = '1;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // One SCLK edge: odd edges lead, even edges trail. The sampling edge is
        // the leading one for CPHA=0 and the trailing one for CPHA=1; the other
        // edge shifts out the next bit (none after the final edge).
        if (fire) begin
            sclk_d = ~sclk_q;
            edg_d  = edg_nxt;
            if (edg_nxt[0] ^ cpha_q) begin
                rx_d = push_bit(rx_q, bus.miso, lsb_q);
            end else if (edg_nxt != EDGE_LAST) begin
                mosi_d = head_bit(tx_q, lsb_q);
                tx_d   = drop_head(tx_q, lsb_q);
            end
        end
    end

    // Register every piece of state; reset abandons any transfer silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from the values of the previous cycle.
        if (rst) begin
            // NOTE: the data registers are small flops, not memories, so they
            // are cleared along with the control state.
            state_q <= IDLE;
            cnt_q   <= '0;
            edg_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cs_n_q  <= '1;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            edg_q   <= edg_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cs_n_q  <= cs_n_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.sclk = sclk_q;
    assign bus.cs_n = cs_n_q;
    assign bus.mosi = mosi_q;
    assign bus.dout = dout_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised SPI master, successor to the fixed 12-bit, mode-0, single-slave master. Adds:
- configurable word width and SCLK divider
- runtime-selectable CPOL/CPHA and bit order
- full-duplex MISO capture
- multiple one-hot active-low chip selects

Sits between the system-side command logic (newd/din) and the SPI pins. It is verified against the existing behavioural slave and loopback benches.

Parameters:
DATA_W, 12, bits per transfer (>=2)
CLK_DIV, 4, clk cycles per SCLK half-period (>=1)
NUM_CS, 1, number of chip-select outputs (>=1)
CS_W, max(1,$clog2(NUM_CS)), width of cs_sel (derived, not overridden)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
newd  in  1  start request, sampled only in IDLE
din  in  DATA_W  transmit word, latched with newd
cs_sel  in  CS_W  target slave index, latched with newd
cpol  in  1  clock polarity, latched with newd
cpha  in  1  clock phase, latched with newd
lsb_first  in  1  1 = LSB shifted first, latched with newd
miso  in  1  serial data from slave
sclk  out  1  SPI clock
cs_n  out  NUM_CS  active-low chip selects, one-hot-low when active
mosi  out  1  serial data to slave
dout  out  DATA_W  received word, updated at done
done  out  1  one-cycle pulse at transfer end
busy  out  1  high from the cycle after accepted newd until the done cycle inclusive

Behaviour:
- Reset values (the cycle after rst is sampled high, from any state): state IDLE, sclk 0, cs_n all 1, mosi 0, dout 0, done 0, busy 0, latched mode 0. A transfer in progress is abandoned with no done pulse.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - sclk = registered cpol input.
  - If newd=1 and cs_sel<NUM_CS at cycle N: latch din/cs_sel/cpol/cpha/lsb_first, go to SETUP.
  - If newd=1 and cs_sel>=NUM_CS: request dropped, stay IDLE, no done.
  - newd while not in IDLE is ignored (no queueing).
- SETUP (entered N+1):
  - cs_n[sel]=0, sclk=cpol, busy=1.
  - If cpha=0, mosi = first bit (din[DATA_W-1], or din[0] if lsb_first).
  - After CLK_DIV cycles go to SHIFT.
- SHIFT:
  - Half-period counter 0..CLK_DIV-1; sclk toggles when it wraps.
  - Edge k (k=1..2*DATA_W) occurs at cycle N+1+k*CLK_DIV. Odd k = leading edge, even k = trailing edge.
  - cpha=0: sample miso on leading edges; drive next bit on trailing edges, except the last trailing edge.
  - cpha=1: drive bit on leading edges (first bit on edge 1); sample miso on trailing edges.
  - Received bits assemble into a shift register in the order given by lsb_first (same order as transmit).
  - After edge 2*DATA_W (sclk back at cpol), go to HOLD.
- HOLD:
  - sclk=cpol, cs_n still asserted, for CLK_DIV cycles.
  - Then at cycle N+1+(2*DATA_W+1)*CLK_DIV: cs_n all 1, dout <= shift register, done=1, busy=1 for that cycle, return IDLE.
- Latency: default params give done at N+101. A new newd is accepted the cycle after done (back-to-back; cs_n high for at least 1 cycle).
- mosi holds its last value outside SHIFT, until the next SETUP or reset.
- dout holds its value until the next done or reset.
- Counter widths are sized to CLK_DIV and 2*DATA_W; no wrap beyond the edge count.

Test Plan:
1. Defaults, mode 0, msb-first, miso looped to mosi, din=0xA5C, newd at cycle N -> cs_n low N+1; 12 rising sclk edges; done pulse exactly at N+101 with dout=0xA5C; busy low at N+102.
2. cpol=1, cpha=1, lsb_first=1, din=0x001, miso tied 1 -> sclk idles high; first mosi bit 1, then zeros; dout=0xFFF; sclk high after done.
3. newd re-asserted with din=0x3FF at N+10 during transfer of 0x123 (loopback) -> ignored: single done, dout=0x123, exactly 24 sclk edges.
4. NUM_CS=4: cs_sel=2 -> only cs_n[2] low for transfer. cs_sel=5 (CS_W=2 so use NUM_CS=3, cs_sel=3) -> no cs_n low, no sclk activity, no done.
5. rst=1 at N+40 mid-transfer -> next cycle cs_n all 1, sclk 0, busy 0, dout 0, no done. New newd after reset completes normally.
6. DATA_W=16, CLK_DIV=1, back-to-back newd on the cycle after each done, loopback 0xBEEF then 0x1234 -> done at N+34 with dout=0xBEEF, then second done 34 cycles after the second accept with dout=0x1234.
